// File: rtl/noc_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one NOC output pipe among NREQ requesters.
// Grant is held for a whole packet (until last or MAXLEN beats); output is a single registered slot.
module noc_packet_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 128,
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned LW     = 5,
  localparam int unsigned GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    enq_valid,
  input  logic [NREQ*DW-1:0] enq_data,
  input  logic [NREQ-1:0]    enq_last,
  output logic [NREQ-1:0]    enq_ready,
  output logic               deq_valid,
  output logic [DW-1:0]      deq_data,
  output logic               deq_last,
  output logic [LW-1:0]      deq_length,
  input  logic               deq_ready,
  output logic [GW-1:0]      grant,
  output logic               busy,
  output logic               trunc_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            vld_q, vld_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            trunc_q, trunc_d;

  logic            slot_free;
  logic            found;
  logic [GW-1:0]   pick;
  logic            beat_valid;
  logic            beat_last;
  logic [DW-1:0]   beat_data;
  logic            hit_max;
  logic            pkt_end;

  assign slot_free = !vld_q || deq_ready;
  assign hit_max   = (cnt_q + LW'(1)) == LW'(MAXLEN);

  // Select the current grantee's beat.
  always_comb begin
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == grant_q) begin
        beat_valid = enq_valid[i];
        beat_last  = enq_last[i];
        beat_data  = enq_data[i*DW +: DW];
      end
    end
  end

  // Round-robin search starting at grant+1, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && enq_valid[i] && ((32'(grant_q) + k) % NREQ) == i) begin
          found = 1'b1;
          pick  = GW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    vld_d     = vld_q;
    data_d    = data_q;
    last_d    = last_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    enq_ready = '0;
    pkt_end   = 1'b0;

    if (vld_q && deq_ready) vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (GW'(i) == grant_q) enq_ready[i] = slot_free;
        end
        if (beat_valid && slot_free) begin
          pkt_end = beat_last || hit_max;
          vld_d   = 1'b1;
          data_d  = beat_data;
          last_d  = pkt_end;
          cnt_d   = cnt_q + LW'(1);
          if (pkt_end) begin
            len_d   = cnt_q + LW'(1);
            cnt_d   = '0;
            state_d = IDLE;
          end
          // Forced termination: remaining beats re-arbitrate as a new packet.
          if (!beat_last && hit_max) trunc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= GW'(NREQ - 1);
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign deq_valid  = vld_q;
  assign deq_data   = data_q;
  assign deq_last   = last_q;
  assign deq_length = len_q;
  assign grant      = grant_q;
  assign busy       = (state_q == BUSY);
  assign trunc_err  = trunc_q;

endmodule

// File: doc/noc_packet_arbiter.md
Name: noc_packet_arbiter

Overview:
- Packet-level round-robin arbiter that shares one NOC output pipe among NREQ PipeIn-style requesters.
- Uses each requester's last flag to hold the grant for a whole packet, so beats from different packets never interleave.
- Reports the beat length of every forwarded packet, PipeInLength style.
- Sits between the endpoint request queues and the NOC head port.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 128, NOCDataH beat width
- MAXLEN, 16, maximum beats per packet before forced truncation
- LW, 5, width of the length counter/output (must hold MAXLEN)

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- enq_valid  input  NREQ  per-requester beat valid
- enq_data  input  NREQ*DW  per-requester beat data; requester i occupies bits [i*DW +: DW]
- enq_last  input  NREQ  per-requester last-beat flag
- enq_ready  output  NREQ  per-requester accept
- deq_valid  output  1  output beat valid
- deq_data  output  DW  output beat data
- deq_last  output  1  output last-beat flag
- deq_length  output  LW  packet beat count, meaningful when deq_valid && deq_last
- deq_ready  input  1  downstream accept
- grant  output  log2(NREQ)  index of the current or most recent grantee
- busy  output  1  a packet is in flight
- trunc_err  output  1  sticky: a packet was force-terminated at MAXLEN beats

Behaviour:
- Reset (RST high at a CLK edge, regardless of state):
  - state=IDLE; grant=NREQ-1, so requester 0 has first priority.
  - deq_valid=0, deq_last=0, deq_length=0, deq_data=0.
  - beat counter=0, trunc_err=0, enq_ready=0.
  - A packet in flight is dropped silently; no deq_last is emitted for it.
- Transfers:
  - Input beat transfers when enq_valid[i] && enq_ready[i].
  - Output beat transfers when deq_valid && deq_ready.
  - deq_valid, deq_data, deq_last and deq_length hold stable until the output beat transfers.
- FSM IDLE:
  - enq_ready=0.
  - If any enq_valid is set, select the first set bit scanning from grant+1 modulo NREQ, load grant, go to BUSY.
  - This costs one arbitration cycle per packet.
- FSM BUSY:
  - enq_ready[grant] = !deq_valid || deq_ready. All other ready bits are 0.
  - Output stage is one registered slot. An accepted input beat appears on deq_* the next cycle: one-cycle latency.
  - Full-throughput streaming: a new beat is accepted in the same cycle the held beat transfers.
- Beat counting:
  - cnt increments on each accepted beat.
  - deq_length = cnt+1, registered with the last beat.
- Packet end:
  - On an accepted beat with enq_last=1, the outgoing beat has deq_last=1. FSM returns to IDLE and grant is retained for the round-robin pointer.
  - If an accepted beat is the MAXLEN-th beat and enq_last=0:
    - force deq_last=1 and deq_length=MAXLEN;
    - set trunc_err;
    - return to IDLE.
  - The requester's remaining beats are then arbitrated as a new packet.
- IDLE may re-arbitrate while the last beat is still held in the output slot. The next packet's first beat waits for that slot to drain.
- Simultaneous requests are resolved only by round-robin order. A requester that drops enq_valid mid-packet stalls the grant; there is no timeout.
- busy = (state==BUSY).
- Width rules:
  - cnt is LW bits wide and never exceeds MAXLEN.
  - grant wraps modulo NREQ. Requester indices at or above NREQ are never granted.
- Values on enq_data and enq_last are don't-care when enq_valid=0.

Test Plan:
- Reset, then requester 2 sends a 3-beat packet with deq_ready=1. Required: grant=2; beats appear on deq_* starting the cycle after the first accept; the 3rd beat has deq_last=1, deq_length=3; busy drops after the last accept.
- Requesters 0, 1 and 3 hold 2-beat packets simultaneously after reset. Required: packets are output in order 0, 1, 3; no interleaving; each has deq_length=2.
- deq_ready toggles 1,0,0,1 during a 4-beat packet. Required: deq_data holds stable while stalled; enq_ready[grant]=0 while the slot is full and deq_ready=0; all 4 beats are delivered in order.
- Requester 1 sends 18 beats with enq_last only on the 18th, MAXLEN=16. Required: beat 16 has deq_last=1, deq_length=16; trunc_err=1; beats 17-18 follow as a new packet with deq_length=2.
- Assert RST for one cycle in the middle of a 5-beat packet. Required: the next cycle shows deq_valid=0, busy=0, trunc_err=0; the next arbitration starts from requester 0.
- Requester 0 sends back-to-back packets while requester 1 is also requesting. Required: grant alternates 0,1,0. Both packets from requester 0 are delivered, in order.
